// File: rtl/ff_pkg.sv
// Shared encodings for the flip-flop bank: operating modes and SR conflict resolution.
package ff_pkg;

   typedef enum logic [1:0] {
      MODE_D  = 2'b00,
      MODE_T  = 2'b01,
      MODE_JK = 2'b10,
      MODE_SR = 2'b11
   } mode_e;

   localparam int PRI_HOLD = 0;
   localparam int PRI_SET  = 1;
   localparam int PRI_RST  = 2;

endpackage

// File: rtl/ff_cell.sv
// One mode-selectable flip-flop: D / T / JK / SR next-state logic plus its register.
module ff_cell
   import ff_pkg::*;
#(
   parameter int SR_PRI = PRI_HOLD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   output logic       q
);

   logic q_nxt;

   // Resolution of the S=R=1 case; any unknown setting falls back to hold.
   function automatic logic sr_both(input logic q_cur);
      logic r;
      case (SR_PRI)
         PRI_SET: r = 1'b1;
         PRI_RST: r = 1'b0;
         default: r = q_cur;
      endcase
      return r;
   endfunction

   // Next state from this channel's operands and current state under the shared mode.
   always_comb begin
      q_nxt = q;
      case (mode_e'(mode))
         MODE_D:  q_nxt = a;
         MODE_T:  q_nxt = q ^ a;
         MODE_JK: begin
            case ({a, b})
               2'b10:   q_nxt = 1'b1;
               2'b01:   q_nxt = 1'b0;
               2'b11:   q_nxt = ~q;
               default: q_nxt = q;
            endcase
         end
         MODE_SR: begin
            case ({a, b})
               2'b10:   q_nxt = 1'b1;
               2'b01:   q_nxt = 1'b0;
               2'b11:   q_nxt = sr_both(q);
               default: q_nxt = q;
            endcase
         end
         default: q_nxt = q;
      endcase
   end

   // State register; reset clears immediately, enable gates every update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= 1'b0;
      else if (en)
         q <= q_nxt;
   end

endmodule

// File: rtl/ff_bank_sync.sv
// Bank of WIDTH mode-selectable flip-flops with sticky SR-conflict flags and a saturating event counter.
module ff_bank_sync
   import ff_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SR_PRI = PRI_HOLD,
   parameter int ILL_CW = 4
) (
   input  logic              CK,
   input  logic              RB,
   input  logic              EN,
   input  logic [1:0]        MODE,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic              CLR_ILL,
   output logic [WIDTH-1:0]  Q,
   output logic [WIDTH-1:0]  QB,
   output logic [WIDTH-1:0]  ILL,
   output logic [ILL_CW-1:0] ILL_CNT
);

   localparam logic [ILL_CW-1:0] CNT_ONE = ILL_CW'(1);

   logic [WIDTH-1:0] ill_evt;
   logic             ill_any;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [ILL_CW-1:0] sat_inc(input logic [ILL_CW-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_cell #(
         .SR_PRI (SR_PRI)
      ) u_cell (
         .clk   (CK),
         .rst_n (RB),
         .en    (EN),
         .mode  (MODE),
         .a     (A[i]),
         .b     (B[i]),
         .q     (Q[i])
      );
   end

   assign QB = ~Q;

   // An illegal event needs an enabled SR-mode edge with S and R both high on that channel.
   always_comb begin
      ill_evt = '0;
      if (EN && (mode_e'(MODE) == MODE_SR))
         ill_evt = A & B;
      ill_any = |ill_evt;
   end

   // Sticky flags and event count; clear beats a coincident event and ignores EN.
   always_ff @(posedge CK or negedge RB) begin
      if (!RB) begin
         ILL     <= '0;
         ILL_CNT <= '0;
      end else if (CLR_ILL) begin
         ILL     <= '0;
         ILL_CNT <= '0;
      end else if (ill_any) begin
         ILL     <= ILL | ill_evt;
         ILL_CNT <= sat_inc(ILL_CNT);
      end
   end

endmodule

// File: tb/tb_ff_bank_sync.sv
// Directed bench for ff_bank_sync: three instances differing only in SR_PRI share all inputs.
module tb_ff_bank_sync;
   import ff_pkg::*;

   logic       CK, RB, EN, CLR_ILL;
   logic [1:0] MODE;
   logic [7:0] A, B;
   logic [7:0] q0, qb0, ill0, q1, qb1, ill1, q2, qb2, ill2;
   logic [3:0] cnt0, cnt1, cnt2;
   logic       mon_on;
   int         checks, errors;

   ff_bank_sync #(.WIDTH(8), .SR_PRI(PRI_HOLD), .ILL_CW(4)) dut0 (
      .CK(CK), .RB(RB), .EN(EN), .MODE(MODE), .A(A), .B(B), .CLR_ILL(CLR_ILL),
      .Q(q0), .QB(qb0), .ILL(ill0), .ILL_CNT(cnt0));
   ff_bank_sync #(.WIDTH(8), .SR_PRI(PRI_SET), .ILL_CW(4)) dut1 (
      .CK(CK), .RB(RB), .EN(EN), .MODE(MODE), .A(A), .B(B), .CLR_ILL(CLR_ILL),
      .Q(q1), .QB(qb1), .ILL(ill1), .ILL_CNT(cnt1));
   ff_bank_sync #(.WIDTH(8), .SR_PRI(PRI_RST), .ILL_CW(4)) dut2 (
      .CK(CK), .RB(RB), .EN(EN), .MODE(MODE), .A(A), .B(B), .CLR_ILL(CLR_ILL),
      .Q(q2), .QB(qb2), .ILL(ill2), .ILL_CNT(cnt2));

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // QB must mirror Q on every cycle of every scenario.
   always @(negedge CK) begin
      if (mon_on) begin
         checks += 3;
         if (qb0 !== ~q0) begin errors++; $display("FAIL qb_inv0 QB=%h Q=%h", qb0, q0); end
         if (qb1 !== ~q1) begin errors++; $display("FAIL qb_inv1 QB=%h Q=%h", qb1, q1); end
         if (qb2 !== ~q2) begin errors++; $display("FAIL qb_inv2 QB=%h Q=%h", qb2, q2); end
      end
   end

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic test_reset();
      RB = 1'b0; EN = 1'b1; CLR_ILL = 1'b0; MODE = 2'b00; A = 8'h00; B = 8'h00;
      #2;
      checks += 3;
      if (q0 !== 8'h00) begin errors++; $display("FAIL rst_init_q Q=%h exp=00", q0); end
      if (ill0 !== 8'h00) begin errors++; $display("FAIL rst_init_ill ILL=%h exp=00", ill0); end
      if (cnt0 !== 4'd0) begin errors++; $display("FAIL rst_init_cnt CNT=%0d exp=0", cnt0); end
      step();
      RB = 1'b1;
      // seed a flag so the mid-cycle reset has something to clear
      MODE = 2'b11; A = 8'h01; B = 8'h01;
      step();
      MODE = 2'b00; A = 8'hA5; B = 8'h00;
      step();
      checks += 3;
      if (q0 !== 8'hA5) begin errors++; $display("FAIL rst_pre_q Q=%h exp=a5", q0); end
      if (ill0 !== 8'h01) begin errors++; $display("FAIL rst_pre_ill ILL=%h exp=01", ill0); end
      if (cnt0 !== 4'd1) begin errors++; $display("FAIL rst_pre_cnt CNT=%0d exp=1", cnt0); end
      #2;
      RB = 1'b0;
      #1;
      checks += 5;
      if (q0 !== 8'h00) begin errors++; $display("FAIL rst_async_q Q=%h exp=00", q0); end
      if (qb0 !== 8'hFF) begin errors++; $display("FAIL rst_async_qb QB=%h exp=ff", qb0); end
      if (ill0 !== 8'h00) begin errors++; $display("FAIL rst_async_ill ILL=%h exp=00", ill0); end
      if (cnt0 !== 4'd0) begin errors++; $display("FAIL rst_async_cnt CNT=%0d exp=0", cnt0); end
      if (q2 !== 8'h00) begin errors++; $display("FAIL rst_async_q2 Q=%h exp=00", q2); end
      step();
      checks += 1;
      if (q0 !== 8'h00) begin errors++; $display("FAIL rst_held_q Q=%h exp=00", q0); end
      #2;
      RB = 1'b1;
      step();
      checks += 1;
      if (q0 !== 8'hA5) begin errors++; $display("FAIL rst_release_q Q=%h exp=a5", q0); end
   endtask

   task automatic test_dt();
      MODE = 2'b00; A = 8'h3C;
      step();
      checks += 1;
      if (q0 !== 8'h3C) begin errors++; $display("FAIL d_load Q=%h exp=3c", q0); end
      MODE = 2'b01; A = 8'hFF;
      step();
      checks += 1;
      if (q0 !== 8'hC3) begin errors++; $display("FAIL t_tog1 Q=%h exp=c3", q0); end
      step();
      checks += 1;
      if (q0 !== 8'h3C) begin errors++; $display("FAIL t_tog2 Q=%h exp=3c", q0); end
      A = 8'h0F;
      step();
      checks += 1;
      if (q0 !== 8'h33) begin errors++; $display("FAIL t_partial Q=%h exp=33", q0); end
   endtask

   task automatic test_jk();
      MODE = 2'b00; A = 8'h0F; B = 8'h00;
      step();
      MODE = 2'b10; A = 8'hF0; B = 8'h0F;
      step();
      checks += 1;
      if (q0 !== 8'hF0) begin errors++; $display("FAIL jk_setrst Q=%h exp=f0", q0); end
      A = 8'hFF; B = 8'hFF;
      step();
      checks += 1;
      if (q0 !== 8'h0F) begin errors++; $display("FAIL jk_toggle Q=%h exp=0f", q0); end
      A = 8'h00; B = 8'h00;
      step();
      checks += 1;
      if (q0 !== 8'h0F) begin errors++; $display("FAIL jk_hold Q=%h exp=0f", q0); end
   endtask

   task automatic test_sr_illegal();
      MODE = 2'b00; A = 8'h00; B = 8'h00; CLR_ILL = 1'b1;
      step();
      CLR_ILL = 1'b0;
      MODE = 2'b11; A = 8'h01; B = 8'h00;
      step();
      checks += 3;
      if (q0 !== 8'h01) begin errors++; $display("FAIL sr_set0 Q=%h exp=01", q0); end
      if (q1 !== 8'h01) begin errors++; $display("FAIL sr_set1 Q=%h exp=01", q1); end
      if (q2 !== 8'h01) begin errors++; $display("FAIL sr_set2 Q=%h exp=01", q2); end
      A = 8'h01; B = 8'h01;
      step();
      checks += 9;
      if (q0 !== 8'h01) begin errors++; $display("FAIL sr_hold_pri Q=%h exp=01", q0); end
      if (q1 !== 8'h01) begin errors++; $display("FAIL sr_set_pri Q=%h exp=01", q1); end
      if (q2 !== 8'h00) begin errors++; $display("FAIL sr_rst_pri Q=%h exp=00", q2); end
      if (ill0 !== 8'h01) begin errors++; $display("FAIL sr_ill0 ILL=%h exp=01", ill0); end
      if (ill1 !== 8'h01) begin errors++; $display("FAIL sr_ill1 ILL=%h exp=01", ill1); end
      if (ill2 !== 8'h01) begin errors++; $display("FAIL sr_ill2 ILL=%h exp=01", ill2); end
      if (cnt0 !== 4'd1) begin errors++; $display("FAIL sr_cnt0 CNT=%0d exp=1", cnt0); end
      if (cnt1 !== 4'd1) begin errors++; $display("FAIL sr_cnt1 CNT=%0d exp=1", cnt1); end
      if (cnt2 !== 4'd1) begin errors++; $display("FAIL sr_cnt2 CNT=%0d exp=1", cnt2); end
      A = 8'h00; B = 8'h01;
      step();
      checks += 1;
      if (q0 !== 8'h00) begin errors++; $display("FAIL sr_reset Q=%h exp=00", q0); end
      A = 8'h01; B = 8'h00;
      step();
   endtask

   task automatic test_saturation();
      logic [3:0] exp_cnt;
      exp_cnt = 4'd1;
      MODE = 2'b11; A = 8'hFF; B = 8'hFF;
      for (int i = 0; i < 20; i++) begin
         step();
         if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
         checks += 1;
         if (cnt0 !== exp_cnt) begin errors++; $display("FAIL sat_cnt edge=%0d CNT=%0d exp=%0d", i, cnt0, exp_cnt); end
      end
      checks += 3;
      if (cnt0 !== 4'd15) begin errors++; $display("FAIL sat_final CNT=%0d exp=15", cnt0); end
      if (ill0 !== 8'hFF) begin errors++; $display("FAIL sat_ill ILL=%h exp=ff", ill0); end
      if (q0 !== 8'h01) begin errors++; $display("FAIL sat_q_hold Q=%h exp=01", q0); end
      A = 8'h01; B = 8'h01; CLR_ILL = 1'b1;
      step();
      CLR_ILL = 1'b0;
      checks += 3;
      if (ill0 !== 8'h00) begin errors++; $display("FAIL clr_ill ILL=%h exp=00", ill0); end
      if (cnt0 !== 4'd0) begin errors++; $display("FAIL clr_cnt CNT=%0d exp=0", cnt0); end
      if (q0 !== 8'h01) begin errors++; $display("FAIL clr_q Q=%h exp=01", q0); end
      A = 8'h00; B = 8'h00;
      step();
      checks += 2;
      if (ill0 !== 8'h00) begin errors++; $display("FAIL clr_lost_ill ILL=%h exp=00", ill0); end
      if (cnt0 !== 4'd0) begin errors++; $display("FAIL clr_lost_cnt CNT=%0d exp=0", cnt0); end
   endtask

   task automatic test_enable();
      logic [1:0] modes [3];
      logic [7:0] av [3];
      logic [7:0] bv [3];
      modes = '{2'b11, 2'b01, 2'b10};
      av    = '{8'hFF, 8'hFF, 8'h0F};
      bv    = '{8'hFF, 8'h00, 8'hF0};
      MODE = 2'b00; A = 8'h5A; B = 8'h00;
      step();
      MODE = 2'b11; A = 8'h80; B = 8'h80;
      step();
      checks += 3;
      if (q0 !== 8'h5A) begin errors++; $display("FAIL en_pre_q Q=%h exp=5a", q0); end
      if (ill0 !== 8'h80) begin errors++; $display("FAIL en_pre_ill ILL=%h exp=80", ill0); end
      if (cnt0 !== 4'd1) begin errors++; $display("FAIL en_pre_cnt CNT=%0d exp=1", cnt0); end
      EN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         MODE = modes[i]; A = av[i]; B = bv[i];
         step();
         checks += 3;
         if (q0 !== 8'h5A) begin errors++; $display("FAIL en_hold_q edge=%0d Q=%h exp=5a", i, q0); end
         if (ill0 !== 8'h80) begin errors++; $display("FAIL en_hold_ill edge=%0d ILL=%h exp=80", i, ill0); end
         if (cnt0 !== 4'd1) begin errors++; $display("FAIL en_hold_cnt edge=%0d CNT=%0d exp=1", i, cnt0); end
      end
      MODE = 2'b00; A = 8'h00; CLR_ILL = 1'b1;
      step();
      CLR_ILL = 1'b0;
      checks += 3;
      if (ill0 !== 8'h00) begin errors++; $display("FAIL en_clr_ill ILL=%h exp=00", ill0); end
      if (cnt0 !== 4'd0) begin errors++; $display("FAIL en_clr_cnt CNT=%0d exp=0", cnt0); end
      if (q0 !== 8'h5A) begin errors++; $display("FAIL en_clr_q Q=%h exp=5a", q0); end
      EN = 1'b1; MODE = 2'b01; A = 8'h00;
      step();
      checks += 1;
      if (q0 !== 8'h5A) begin errors++; $display("FAIL mode_change_q Q=%h exp=5a", q0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'hE7, 8'h00};
      MODE = 2'b00;
      for (int i = 0; i < 4; i++) begin
         A = vals[i];
         step();
         checks += 1;
         if (q0 !== vals[i]) begin errors++; $display("FAIL b2b idx=%0d Q=%h exp=%h", i, q0, vals[i]); end
      end
   endtask

   initial begin
      checks = 0; errors = 0; mon_on = 1'b1;
      test_reset();
      test_dt();
      test_jk();
      test_sr_illegal();
      test_saturation();
      test_enable();
      test_back_to_back();
      @(negedge CK);
      mon_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
